// File: rtl/draw_cursor_sprite_pkg.sv
// Shared types, constants and sprite bitmap generator for the cursor overlay stage.
package draw_cursor_sprite_pkg;

    localparam int unsigned HC_W      = 11;
    localparam int unsigned RGB_W     = 12;
    localparam int unsigned CUR_PIX_W = 2;

    localparam logic [RGB_W-1:0] COL_BLACK = 12'h000;
    localparam logic [RGB_W-1:0] COL_WHITE = 12'hFFF;

    typedef enum logic [1:0] {
        CUR_HIDDEN = 2'b00,
        CUR_ARROW  = 2'b01,
        CUR_CROSS  = 2'b10
    } cursor_mode_t;

    typedef enum logic {
        PH_VISIBLE = 1'b0,
        PH_HIDDEN  = 1'b1
    } blink_phase_t;

    typedef struct packed {
        logic [HC_W-1:0]  hcount;
        logic [HC_W-1:0]  vcount;
        logic             hsync;
        logic             vsync;
        logic             hblnk;
        logic             vblnk;
        logic [RGB_W-1:0] rgb;
    } vga_t;

    function automatic cursor_mode_t decode_mode(input logic [1:0] m);
        case (m)
            2'b01:   return CUR_ARROW;
            2'b10:   return CUR_CROSS;
            default: return CUR_HIDDEN;
        endcase
    endfunction

    // Bank 0: left-aligned triangular arrow (outline edges, filled body).
    // Bank 1: one-pixel inverting crosshair through the sprite centre.
    function automatic logic [CUR_PIX_W-1:0] cursor_pixel(
        input logic        bank,
        input int unsigned row,
        input int unsigned col,
        input int unsigned w,
        input int unsigned h
    );
        if (!bank) begin
            if (col > row)                                return 2'd0;
            if (row == h - 1 || col == 0 || col == row)   return 2'd1;
            return 2'd2;
        end
        if (row == h / 2 || col == w / 2) return 2'd3;
        return 2'd0;
    endfunction

endpackage

// File: rtl/draw_cursor_sprite_if.sv
// VGA timing + colour bundle passed between pipeline stages.
interface vga_if;
    import draw_cursor_sprite_pkg::*;

    logic [HC_W-1:0]  hcount;
    logic [HC_W-1:0]  vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;
    logic [RGB_W-1:0] rgb;

    modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_cursor_sprite_rom.sv
// Two-bank 2-bit cursor sprite ROM, synchronous read with one cycle of latency.
module cursor_rom
    import draw_cursor_sprite_pkg::*;
#(
    parameter int unsigned SPRITE_W = 16,
    parameter int unsigned SPRITE_H = 16,
    localparam int unsigned AW_X = $clog2(SPRITE_W),
    localparam int unsigned AW_Y = $clog2(SPRITE_H),
    localparam int unsigned AW   = 1 + AW_Y + AW_X
) (
    input  logic                 clk,
    input  logic [AW-1:0]        addr_i,
    output logic [CUR_PIX_W-1:0] data_o
);

    logic [CUR_PIX_W-1:0] data_q;

    always_ff @(posedge clk) begin
        data_q <= cursor_pixel(addr_i[AW-1],
                               int'(addr_i[AW_Y+AW_X-1:AW_X]),
                               int'(addr_i[AW_X-1:0]),
                               SPRITE_W, SPRITE_H);
    end

    assign data_o = data_q;

endmodule

// File: rtl/draw_cursor_sprite.sv
// Cursor overlay stage: per-frame position latch, blink control, hit test and
// a two-cycle pipeline that mixes sprite colours into the incoming pixel stream.
module draw_cursor_sprite
    import draw_cursor_sprite_pkg::*;
#(
    parameter int unsigned      SPRITE_W     = 16,
    parameter int unsigned      SPRITE_H     = 16,
    parameter int unsigned      BLINK_FRAMES = 30,
    parameter logic [RGB_W-1:0] COL_OUTLINE  = COL_BLACK,
    parameter logic [RGB_W-1:0] COL_FILL     = COL_WHITE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    input  logic [1:0]  mode,
    input  logic        blink_en,
    vga_if.slave        in,
    vga_if.master       out
);

    localparam int unsigned AW_X = $clog2(SPRITE_W);
    localparam int unsigned AW_Y = $clog2(SPRITE_H);
    localparam int unsigned CW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_FRAMES - 1);

    logic         vblnk_prev_q;
    logic         vblnk_rise;
    logic [11:0]  x_l_q, y_l_q;
    cursor_mode_t mode_l_q;

    blink_phase_t phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          visible;

    logic [12:0] hc13, vc13, xl13, yl13;
    logic        hit_s1;
    logic [AW_X-1:0] col;
    logic [AW_Y-1:0] row;
    logic [CUR_PIX_W-1:0] rom_data;

    vga_t s1_d, s1_q, s2_d, s2_q;
    logic hit1_q;

    assign vblnk_rise = in.vblnk & ~vblnk_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vblnk_prev_q <= 1'b0;
            x_l_q        <= '0;
            y_l_q        <= '0;
            mode_l_q     <= CUR_HIDDEN;
        end else begin
            vblnk_prev_q <= in.vblnk;
            if (vblnk_rise) begin
                x_l_q    <= xpos;
                y_l_q    <= ypos;
                mode_l_q <= decode_mode(mode);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= PH_VISIBLE;
            cnt_q   <= '0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        if (!blink_en) begin
            phase_d = PH_VISIBLE;
            cnt_d   = '0;
        end else if (vblnk_rise) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                phase_d = (phase_q == PH_VISIBLE) ? PH_HIDDEN : PH_VISIBLE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign visible = (mode_l_q == CUR_ARROW || mode_l_q == CUR_CROSS)
                   && (phase_q == PH_VISIBLE || !blink_en);

    // 13-bit compare keeps x+SPRITE_W from wrapping back onto the left edge.
    assign hc13 = {2'b00, in.hcount};
    assign vc13 = {2'b00, in.vcount};
    assign xl13 = {1'b0, x_l_q};
    assign yl13 = {1'b0, y_l_q};

    assign hit_s1 = (hc13 >= xl13) && (hc13 < xl13 + 13'(SPRITE_W))
                 && (vc13 >= yl13) && (vc13 < yl13 + 13'(SPRITE_H))
                 && !in.hblnk && !in.vblnk && visible;

    assign col = AW_X'({1'b0, in.hcount} - x_l_q);
    assign row = AW_Y'({1'b0, in.vcount} - y_l_q);

    cursor_rom #(
        .SPRITE_W (SPRITE_W),
        .SPRITE_H (SPRITE_H)
    ) u_rom (
        .clk    (clk),
        .addr_i ({mode_l_q == CUR_CROSS, row, col}),
        .data_o (rom_data)
    );

    always_comb begin
        s1_d.hcount = in.hcount;
        s1_d.vcount = in.vcount;
        s1_d.hsync  = in.hsync;
        s1_d.vsync  = in.vsync;
        s1_d.hblnk  = in.hblnk;
        s1_d.vblnk  = in.vblnk;
        s1_d.rgb    = in.rgb;
    end

    always_comb begin
        s2_d = s1_q;
        if (hit1_q) begin
            case (rom_data)
                2'd1:    s2_d.rgb = COL_OUTLINE;
                2'd2:    s2_d.rgb = COL_FILL;
                2'd3:    s2_d.rgb = ~s1_q.rgb;
                default: s2_d.rgb = s1_q.rgb;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= '0;
            hit1_q <= 1'b0;
            s2_q   <= '0;
        end else begin
            s1_q   <= s1_d;
            hit1_q <= hit_s1;
            s2_q   <= s2_d;
        end
    end

    assign out.hcount = s2_q.hcount;
    assign out.vcount = s2_q.vcount;
    assign out.hsync  = s2_q.hsync;
    assign out.vsync  = s2_q.vsync;
    assign out.hblnk  = s2_q.hblnk;
    assign out.vblnk  = s2_q.vblnk;
    assign out.rgb    = s2_q.rgb;

endmodule

// File: tb/tb_draw_cursor_sprite.sv
// Directed bench for draw_cursor_sprite with a shortened blink period.
module tb_draw_cursor_sprite;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] xpos, ypos;
    logic [1:0]  mode;
    logic        blink_en;

    int n_checks = 0;
    int n_fail   = 0;

    vga_if vin ();
    vga_if vout ();

    draw_cursor_sprite #(
        .SPRITE_W     (16),
        .SPRITE_H     (16),
        .BLINK_FRAMES (2),
        .COL_OUTLINE  (12'h000),
        .COL_FILL     (12'hFFF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .xpos     (xpos),
        .ypos     (ypos),
        .mode     (mode),
        .blink_en (blink_en),
        .in       (vin),
        .out      (vout)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One pixel in, idle blanked pixel after it, result read 2 edges later.
    task automatic probe(input logic [10:0] h, input logic [10:0] v,
                         input logic [11:0] rgb, input logic hb,
                         output logic [11:0] got);
        vin.hcount = h;
        vin.vcount = v;
        vin.rgb    = rgb;
        vin.hblnk  = hb;
        vin.vblnk  = 1'b0;
        @(posedge clk);
        #1;
        vin.hblnk = 1'b1;
        @(posedge clk);
        #1;
        got = vout.rgb;
    endtask

    task automatic vblank();
        vin.vblnk = 1'b1;
        vin.hblnk = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        vin.vblnk = 1'b0;
    endtask

    task automatic test_reset();
        logic [27:0] exp_t, got_t;
        logic [11:0] exp_rgb;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        vin.hcount = 11'd5; vin.vcount = 11'd7; vin.rgb = 12'hABC;
        vin.hsync = 1'b1; vin.vsync = 1'b1; vin.hblnk = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            got_t = {vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk};
            n_checks++;
            if (got_t !== '0 || vout.rgb !== 12'h000) begin
                n_fail++;
                $display("FAIL reset_zero[%0d]: got %h/%h expected 0/0", c, got_t, vout.rgb);
            end
        end
        for (int i = 0; i < 6; i++) begin
            rst = 1'b0;
            vin.hcount = 11'(10 + i);
            vin.vcount = 11'(20 + i);
            vin.hsync  = i[0];
            vin.vsync  = ~i[0];
            vin.hblnk  = i[1];
            vin.vblnk  = 1'b0;
            vin.rgb    = 12'(12'h100 + i);
            @(posedge clk);
            #1;
            if (i == 0) begin
                exp_t   = '0;
                exp_rgb = 12'h000;
            end else begin
                exp_t   = {11'(10 + i - 1), 11'(20 + i - 1), 1'((i - 1) & 1),
                           ~1'((i - 1) & 1), 1'(((i - 1) >> 1) & 1), 1'b0};
                exp_rgb = 12'(12'h100 + i - 1);
            end
            got_t = {vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk};
            n_checks++;
            if (got_t !== exp_t || vout.rgb !== exp_rgb) begin
                n_fail++;
                $display("FAIL latency2[%0d]: got %h/%h expected %h/%h", i, got_t, vout.rgb, exp_t, exp_rgb);
            end
        end
        vin.hsync = 1'b0;
        vin.vsync = 1'b0;
    endtask

    task automatic test_arrow();
        logic [11:0] got;
        logic [10:0] hs [7] = '{100, 99, 116, 100, 100, 102, 106};
        logic [10:0] vs [7] = '{50, 50, 50, 65, 66, 55, 55};
        logic [11:0] ex [7] = '{12'h000, 12'h123, 12'h123, 12'h000, 12'h123, 12'hFFF, 12'h123};
        xpos = 12'd100; ypos = 12'd50; mode = 2'b01; blink_en = 1'b0;
        probe(11'd100, 11'd50, 12'h123, 1'b0, got);
        n_checks++;
        if (got !== 12'h123) begin
            n_fail++;
            $display("FAIL arrow_before_latch: got %h expected %h", got, 12'h123);
        end
        vblank();
        for (int k = 0; k < 7; k++) begin
            probe(hs[k], vs[k], 12'h123, 1'b0, got);
            n_checks++;
            if (got !== ex[k]) begin
                n_fail++;
                $display("FAIL arrow_px(%0d,%0d): got %h expected %h", hs[k], vs[k], got, ex[k]);
            end
        end
        probe(11'd100, 11'd50, 12'h123, 1'b1, got);
        n_checks++;
        if (got !== 12'h123) begin
            n_fail++;
            $display("FAIL arrow_hblnk: got %h expected %h", got, 12'h123);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] ex [9] = '{12'h123, 12'h123, 12'h000, 12'hFFF, 12'hFFF,
                                12'hFFF, 12'hFFF, 12'h000, 12'h123};
        for (int i = 0; i <= 9; i++) begin
            if (i < 9) begin
                vin.hcount = 11'(98 + i);
                vin.vcount = 11'd55;
                vin.rgb    = 12'h123;
                vin.hblnk  = 1'b0;
            end else begin
                vin.hblnk = 1'b1;
            end
            @(posedge clk);
            #1;
            if (i >= 1) begin
                n_checks++;
                if (vout.rgb !== ex[i-1] || vout.hcount !== 11'(98 + i - 1)) begin
                    n_fail++;
                    $display("FAIL stream[%0d]: got %h@%0d expected %h@%0d",
                             i - 1, vout.rgb, vout.hcount, ex[i-1], 98 + i - 1);
                end
            end
        end
    endtask

    task automatic test_midframe_move();
        logic [11:0] got;
        xpos = 12'd100; ypos = 12'd195; mode = 2'b01;
        vblank();
        probe(11'd100, 11'd200, 12'h123, 1'b0, got);
        n_checks++;
        if (got !== 12'h000) begin
            n_fail++;
            $display("FAIL move_before: got %h expected %h", got, 12'h000);
        end
        xpos = 12'd300;
        probe(11'd100, 11'd201, 12'h123, 1'b0, got);
        n_checks++;
        if (got !== 12'h000) begin
            n_fail++;
            $display("FAIL move_old_pos_held: got %h expected %h", got, 12'h000);
        end
        probe(11'd300, 11'd200, 12'h123, 1'b0, got);
        n_checks++;
        if (got !== 12'h123) begin
            n_fail++;
            $display("FAIL move_no_tear: got %h expected %h", got, 12'h123);
        end
        vblank();
        probe(11'd300, 11'd200, 12'h123, 1'b0, got);
        n_checks++;
        if (got !== 12'h000) begin
            n_fail++;
            $display("FAIL move_new_pos: got %h expected %h", got, 12'h000);
        end
        probe(11'd100, 11'd200, 12'h123, 1'b0, got);
        n_checks++;
        if (got !== 12'h123) begin
            n_fail++;
            $display("FAIL move_old_cleared: got %h expected %h", got, 12'h123);
        end
    endtask

    task automatic test_clipping();
        logic [11:0] got;
        logic [10:0] hs [5] = '{630, 639, 635, 3, 630};
        logic [10:0] vs [5] = '{470, 479, 479, 470, 3};
        logic [11:0] ex [5] = '{12'h000, 12'h000, 12'hFFF, 12'h123, 12'h123};
        xpos = 12'd630; ypos = 12'd470; mode = 2'b01;
        vblank();
        for (int k = 0; k < 5; k++) begin
            probe(hs[k], vs[k], 12'h123, 1'b0, got);
            n_checks++;
            if (got !== ex[k]) begin
                n_fail++;
                $display("FAIL clip_px(%0d,%0d): got %h expected %h", hs[k], vs[k], got, ex[k]);
            end
        end
    endtask

    task automatic test_invert();
        logic [11:0] got;
        xpos = 12'd200; ypos = 12'd100; mode = 2'b10;
        vblank();
        probe(11'd208, 11'd100, 12'h0F0, 1'b0, got);
        n_checks++;
        if (got !== 12'hF0F) begin
            n_fail++;
            $display("FAIL invert_code3: got %h expected %h", got, 12'hF0F);
        end
        probe(11'd200, 11'd108, 12'h0F0, 1'b0, got);
        n_checks++;
        if (got !== 12'hF0F) begin
            n_fail++;
            $display("FAIL invert_row: got %h expected %h", got, 12'hF0F);
        end
        probe(11'd201, 11'd101, 12'h0F0, 1'b0, got);
        n_checks++;
        if (got !== 12'h0F0) begin
            n_fail++;
            $display("FAIL transparent_code0: got %h expected %h", got, 12'h0F0);
        end
        mode = 2'b11;
        vblank();
        probe(11'd208, 11'd100, 12'h0F0, 1'b0, got);
        n_checks++;
        if (got !== 12'h0F0) begin
            n_fail++;
            $display("FAIL reserved_mode_hidden: got %h expected %h", got, 12'h0F0);
        end
    endtask

    task automatic test_blink();
        logic [11:0] got;
        logic [11:0] exp_rgb;
        bit vis [7] = '{1, 1, 0, 0, 1, 1, 0};
        xpos = 12'd100; ypos = 12'd50; mode = 2'b01; blink_en = 1'b0;
        vblank();
        blink_en = 1'b1;
        for (int f = 0; f < 7; f++) begin
            probe(11'd100, 11'd50, 12'h123, 1'b0, got);
            exp_rgb = vis[f] ? 12'h000 : 12'h123;
            n_checks++;
            if (got !== exp_rgb) begin
                n_fail++;
                $display("FAIL blink_frame%0d: got %h expected %h", f, got, exp_rgb);
            end
            if (f == 6) blink_en = 1'b0;
            vblank();
        end
        probe(11'd100, 11'd50, 12'h123, 1'b0, got);
        n_checks++;
        if (got !== 12'h000) begin
            n_fail++;
            $display("FAIL blink_disable_visible: got %h expected %h", got, 12'h000);
        end
    endtask

    initial begin
        rst = 1'b1;
        xpos = '0; ypos = '0; mode = 2'b00; blink_en = 1'b0;
        vin.hcount = '0; vin.vcount = '0; vin.rgb = '0;
        vin.hsync = 1'b0; vin.vsync = 1'b0; vin.hblnk = 1'b0; vin.vblnk = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_arrow();
        test_back_to_back();
        test_midframe_move();
        test_clipping();
        test_invert();
        test_blink();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/draw_cursor_sprite.md
Name: draw_cursor_sprite

Overview:
- Parametrised cursor overlay stage in the VGA pipeline, placed after background/rect drawing and before the output register stage.
- Overlays a 2-bit-per-pixel sprite from an internal ROM at a mouse position that is latched once per frame.
- Supports colour palette, mode select (hidden/arrow/crosshair) and optional blinking.
- Delays all timing signals to match its fixed pipeline latency.

Parameters:
- SPRITE_W, 16, sprite width in pixels (power of 2, 8..64)
- SPRITE_H, 16, sprite height in pixels (power of 2, 8..64)
- BLINK_FRAMES, 30, frames per blink half-period (>=1)
- COL_OUTLINE, 12'h000, RGB for code 1
- COL_FILL, 12'hFFF, RGB for code 2

Ports:
- clk  input  1  pixel clock
- rst  input  1  synchronous active-high reset
- xpos  input  12  cursor hotspot x (top-left of sprite)
- ypos  input  12  cursor hotspot y
- mode  input  2  00 hidden, 01 arrow, 10 crosshair, 11 reserved (treated as hidden)
- blink_en  input  1  enable blinking
- in  vga_if.in  -  incoming timing and rgb
- out  vga_if.out  -  outgoing timing and rgb

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - all out fields 0
  - latched x/y = 0, latched mode = hidden
  - blink counter = 0, blink phase = visible
  - all pipeline registers 0
- Latency: exactly 2 clk cycles from in.* to out.* for every field (hcount, vcount, hsync, vsync, hblnk, vblnk, rgb).
  - Stage 1: hit test, ROM address issue, timing delay.
  - Stage 2: ROM data is valid; colour mux; registered output.
- Frame latch: on the cycle in.vblnk rises (in.vblnk=1, previous in.vblnk=0), capture xpos, ypos and mode. Changes to these inputs mid-frame have no effect until the next vblnk rising edge, so there is no tearing.
- Hit test (stage 1), using 13-bit unsigned arithmetic so that x+SPRITE_W cannot wrap:
  - hit = (hcount >= x_l) && (hcount < x_l+SPRITE_W) && (vcount >= y_l) && (vcount < y_l+SPRITE_H) && !hblnk && !vblnk && visible
  - Sprite pixels beyond the screen edge are clipped naturally; there is no wrap to the left or top.
- ROM address = {mode_l[1], vcount-y_l (log2 SPRITE_H bits), hcount-x_l (log2 SPRITE_W bits)}. The arrow bank is selected when mode_l=01, the crosshair bank when mode_l=10.
- Pixel code decode (stage 2, only when delayed hit=1):
  - 0 transparent: pass rgb through
  - 1: COL_OUTLINE
  - 2: COL_FILL
  - 3: inverted, ~rgb_d (bitwise inverse of the delayed input rgb)
- When delayed hit=0: out.rgb = in.rgb delayed 2 cycles.
- Blink:
  - The counter increments on each vblnk rising edge while blink_en=1.
  - At BLINK_FRAMES-1 the counter wraps to 0 and the phase toggles.
  - When blink_en=0, the counter is held at 0 and phase = visible.
  - visible = (mode_l is 01 or 10) && (phase || !blink_en).
- Simultaneous events: a vblnk rising edge coincident with a blink wrap applies both the latch and the toggle in the same cycle; the new values take effect from the next frame's active area.
- Reset mid-frame: outputs are 0 on the next cycle; the cursor stays hidden until the first vblnk rising edge after reset.

Decomposition:
- vga_pkg gains:
  - typedef cursor_mode_t (enum: CUR_HIDDEN, CUR_ARROW, CUR_CROSS)
  - localparam CUR_PIX_W = 2
  - colour constants for defaults
- Sub-module cursor_rom:
  - parameters SPRITE_W, SPRITE_H
  - synchronous read, 1-cycle latency
  - 2 banks (arrow, crosshair) initialised by case/initial, 2-bit data
- Top: frame latch, blink FSM/counter, hit test, 2-stage delay line, colour mux.

Test Plan:
- Reset: rst=1 for 3 cycles mid-line -> all out fields 0. After release, out.hcount tracks in.hcount delayed by exactly 2 cycles.
- Arrow mode, 16x16: xpos=100, ypos=50, mode=01 latched at vblnk. In the next frame:
  - pixel (100,50) shows ROM code-1 colour 12'h000
  - pixels (99,50) and (116,50) pass in.rgb
  - pixels (100,65) draw, (100,66) passes
- Mid-frame move: change xpos 100->300 at vcount=200 -> the rest of the frame still draws at x=100; the next frame draws at x=300.
- Clipping: xpos=630, ypos=470 on 640x480 -> only the 10x10 on-screen region drawn; no pixels at hcount 0..5 or vcount 0..5.
- Inversion/transparency: in.rgb=12'h0F0 under code-3 pixel -> out.rgb=12'hF0F; under code-0 -> 12'h0F0.
- Blink: BLINK_FRAMES=2, blink_en=1 -> cursor visible for frames 0-1, hidden for 2-3, visible for 4-5. Deasserting blink_en -> visible from the next frame.
